ucq_arb: RTL and testbench

Unit-clause queue and arbiter that sits directly upstream of the clause queue (CLQ).
- Collects implied unit literals from NUM_ENG BCP engines through round-robin arbitration.
- Keeps a per-variable assignment table to drop duplicate literals and detect conflicts.
- Presents one literal at a time to the CLQ as ucarb2clq_uc_rqst / ucarb2clq_uc_rqst_valid, holding it until the BCP engine signals completion.

---
 rtl/ucq_arb.sv | 98 +++++++++
 tb/tb_ucq_arb.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ucq_arb.sv
// ucq_arb: round-robin unit-literal arbiter with duplicate/conflict filtering FIFO feeding the CLQ
module ucq_arb #(
    parameter int DEPTH = 16,
    parameter int NUM_ENG = 2,
    parameter int LIT_IDX_MAX = 64,
    localparam int LIT_W = $clog2(LIT_IDX_MAX) + 1,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_ENG*LIT_W-1:0] bcp2ucq_lit,
    input  logic [NUM_ENG-1:0]       bcp2ucq_valid,
    output logic [NUM_ENG-1:0]       ucq2bcp_grant,
    input  logic                     bcp2ucq_done,
    input  logic                     ctrl2ucq_clear,
    output logic [LIT_W-1:0]         ucarb2clq_uc_rqst,
    output logic                     ucarb2clq_uc_rqst_valid,
    output logic                     ucq_conflict,
    output logic [CW-1:0]            ucq_count,
    output logic                     ucq_idle
);
    localparam int PW = $clog2(DEPTH);
    localparam int VW = $clog2(LIT_IDX_MAX);
    localparam int EW = NUM_ENG > 1 ? $clog2(NUM_ENG) : 1;

    logic [LIT_W-1:0]       fifo [DEPTH];
    logic [PW-1:0]          head, tail;
    logic [CW-1:0]          count;
    logic [EW-1:0]          rr_ptr, gidx, rr_next;
    logic [LIT_IDX_MAX-1:0] asg, pol;
    logic [LIT_W-1:0]       g_lit;
    logic [VW-1:0]          v;
    logic                   conflict, found, arb_en, p, push, conf, pop, valid;

    assign arb_en = rst_n && (count != CW'(DEPTH)) && !conflict && !ctrl2ucq_clear;
    assign g_lit = bcp2ucq_lit[int'(gidx)*LIT_W +: LIT_W];
    assign p = g_lit[LIT_W-1];
    assign v = VW'(p ? -g_lit : g_lit);
    assign push = found && !asg[v];
    assign conf = found && asg[v] && (pol[v] != p);
    assign valid = (count != '0) && !conflict;
    assign pop = bcp2ucq_done && valid;
    assign rr_next = (gidx == EW'(NUM_ENG - 1)) ? '0 : gidx + 1'b1;
    assign ucarb2clq_uc_rqst = valid ? fifo[head] : '0;
    assign ucarb2clq_uc_rqst_valid = valid;
    assign ucq_conflict = conflict;
    assign ucq_count = count;
    assign ucq_idle = (count == '0) && !conflict;

    // pick the first requesting engine at or after rr_ptr
    always_comb begin
        found = 1'b0;
        gidx = '0;
        for (int i = 0; i < NUM_ENG; i++) begin
            if (!found && arb_en && bcp2ucq_valid[(int'(rr_ptr) + i) % NUM_ENG]) begin
                found = 1'b1;
                gidx = EW'((int'(rr_ptr) + i) % NUM_ENG);
            end
        end
        ucq2bcp_grant = found ? NUM_ENG'(1) << gidx : '0;
    end

    // literal storage; only newly assigned variables are enqueued
    always_ff @(posedge clk) begin
        if (push)
            fifo[tail] <= g_lit;
    end

    // pointers, occupancy, assignment table, conflict and round-robin state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || ctrl2ucq_clear) begin
            head <= '0;
            tail <= '0;
            count <= '0;
            rr_ptr <= '0;
            asg <= '0;
            pol <= '0;
            conflict <= 1'b0;
        end else begin
            if (found)
                rr_ptr <= rr_next;
            if (conf) begin
                conflict <= 1'b1;
                count <= '0;
                head <= tail;
            end else begin
                if (push) begin
                    asg[v] <= 1'b1;
                    pol[v] <= p;
                    tail <= tail + 1'b1;
                end
                if (pop)
                    head <= head + 1'b1;
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end
endmodule

// File: tb/tb_ucq_arb.sv
// tb_ucq_arb: directed scoreboard bench for the unit-clause queue arbiter
module tb_ucq_arb;
    localparam int LW = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [LW-1:0] l0 = '0, l1 = '0;
    logic [1:0]    vld = '0;
    logic          done = 1'b0, clr = 1'b0;
    logic [1:0]    grant;
    logic [LW-1:0] rqst;
    logic          rqst_valid, conflict, idle;
    logic [4:0]    count;

    int checks = 0;
    int failures = 0;
    logic [LW-1:0] exp_q[$];

    always #5 clk = ~clk;

    ucq_arb dut (
        .clk(clk),
        .rst_n(rst_n),
        .bcp2ucq_lit({l1, l0}),
        .bcp2ucq_valid(vld),
        .ucq2bcp_grant(grant),
        .bcp2ucq_done(done),
        .ctrl2ucq_clear(clr),
        .ucarb2clq_uc_rqst(rqst),
        .ucarb2clq_uc_rqst_valid(rqst_valid),
        .ucq_conflict(conflict),
        .ucq_count(count),
        .ucq_idle(idle)
    );

    task automatic chk(string n, int a, int e);
        checks++;
        if (a != e) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", n, a, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LW-1:0] neg(int m);
        return LW'(-m);
    endfunction

    function automatic bit legal(logic [LW-1:0] l);
        logic [LW-1:0] m;
        m = l[LW-1] ? -l : l;
        return m != 0 && m < 64;
    endfunction

    // monitor: every accepted literal must match the next expected one
    always @(negedge clk) begin
        if (rst_n && done && rqst_valid) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected", int'($signed(rqst)), 0);
            end else begin
                chk("sb_order", int'($signed(rqst)), int'($signed(exp_q.pop_front())));
            end
        end
    end

    // engines must only offer legal literals
    always @(negedge clk) begin
        if (vld[0]) assert (legal(l0)) else $error("illegal literal on eng0");
        if (vld[1]) assert (legal(l1)) else $error("illegal literal on eng1");
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", rqst_valid, 0);
        chk("rst_rqst", rqst, 0);
        chk("rst_grant", grant, 0);
        chk("rst_idle", idle, 1);
        chk("rst_count", count, 0);
        chk("rst_conflict", conflict, 0);
        rst_n = 1'b1;
        step();
        // single push
        l0 = 5;
        vld = 2'b01;
        @(negedge clk);
        chk("t1_grant", grant, 1);
        chk("t1_latency", rqst_valid, 0);
        exp_q.push_back(5);
        step();
        vld = 0;
        chk("t1_valid", rqst_valid, 1);
        chk("t1_rqst", rqst, 5);
        chk("t1_count", count, 1);
        done = 1;
        step();
        done = 0;
        chk("t1_valid0", rqst_valid, 0);
        chk("t1_idle", idle, 1);
        // round-robin after clear resets rr_ptr
        clr = 1;
        step();
        clr = 0;
        l0 = 1;
        l1 = 2;
        vld = 2'b11;
        for (int k = 1; k <= 4; k++) exp_q.push_back(LW'(k));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("t2_grant%0d", k), grant, (k % 2 != 0) ? 2 : 1);
            step();
            if (k == 0) l0 = 3;
            if (k == 1) l1 = 4;
            if (k == 2) vld[0] = 0;
            if (k == 3) vld[1] = 0;
        end
        chk("t2_count", count, 4);
        done = 1;
        repeat (4) step();
        done = 0;
        chk("t2_drained", count, 0);
        // duplicate
        l0 = neg(7);
        vld = 2'b01;
        @(negedge clk);
        chk("t3_grant", grant, 1);
        exp_q.push_back(neg(7));
        step();
        @(negedge clk);
        chk("t3_dup_grant", grant, 1);
        step();
        vld = 0;
        chk("t3_count", count, 1);
        done = 1;
        step();
        done = 0;
        chk("t3_drained", count, 0);
        // conflict
        l0 = 9;
        vld = 2'b01;
        @(negedge clk);
        chk("t4_grant_pos", grant, 1);
        step();
        l0 = neg(9);
        @(negedge clk);
        chk("t4_grant_neg", grant, 1);
        step();
        vld = 0;
        chk("t4_conflict", conflict, 1);
        chk("t4_valid", rqst_valid, 0);
        chk("t4_count", count, 0);
        chk("t4_idle", idle, 0);
        l1 = 10;
        vld = 2'b10;
        done = 1;
        @(negedge clk);
        chk("t4_no_grant", grant, 0);
        step();
        done = 0;
        chk("t4_count_hold", count, 0);
        chk("t4_sticky", conflict, 1);
        clr = 1;
        @(negedge clk);
        chk("t4_clr_grant", grant, 0);
        step();
        clr = 0;
        vld = 0;
        chk("t4_cleared", conflict, 0);
        chk("t4_idle1", idle, 1);
        // fill, full, push+pop and pointer wrap
        vld = 2'b01;
        for (int k = 0; k < 16; k++) begin
            l0 = LW'(11 + k);
            @(negedge clk);
            chk($sformatf("t5_fill%0d", k), grant, 1);
            exp_q.push_back(LW'(11 + k));
            step();
        end
        l0 = 27;
        done = 1;
        @(negedge clk);
        chk("t5_full_grant", grant, 0);
        chk("t5_full_count", count, 16);
        step();
        chk("t5_count15", count, 15);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("t5_pp_grant%0d", k), grant, 1);
            exp_q.push_back(LW'(27 + k));
            step();
            chk($sformatf("t5_pp_count%0d", k), count, 15);
            l0 = LW'(28 + k);
        end
        done = 0;
        @(negedge clk);
        chk("t5_last_grant", grant, 1);
        exp_q.push_back(30);
        step();
        l0 = 31;
        @(negedge clk);
        chk("t5_refull_grant", grant, 0);
        step();
        vld = 0;
        chk("t5_refull_count", count, 16);
        done = 1;
        repeat (16) step();
        done = 0;
        chk("t5_drained", count, 0);
        chk("t5_idle", idle, 1);
        // reset mid-stream
        vld = 2'b01;
        for (int k = 0; k < 5; k++) begin
            l0 = LW'(31 + k);
            @(negedge clk);
            chk($sformatf("t6_push%0d", k), grant, 1);
            step();
        end
        vld = 0;
        chk("t6_count5", count, 5);
        chk("t6_valid1", rqst_valid, 1);
        rst_n = 0;
        l0 = 31;
        vld = 2'b01;
        #1;
        chk("t6_rst_valid", rqst_valid, 0);
        chk("t6_rst_rqst", rqst, 0);
        chk("t6_rst_count", count, 0);
        chk("t6_rst_grant", grant, 0);
        chk("t6_rst_idle", idle, 1);
        @(negedge clk);
        rst_n = 1;
        #1;
        chk("t6_regrant", grant, 1);
        exp_q.push_back(31);
        step();
        vld = 0;
        chk("t6_count1", count, 1);
        chk("t6_rqst", rqst, 31);
        done = 1;
        step();
        done = 0;
        chk("t6_drained", count, 0);
        chk("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
